ld_mem_port: RTL and testbench

- Memory-side server for one handshake load port of the generated `main` dataflow top, e.g. `in0_ld0` / `in1_ld0`.
- Accepts load addresses from the DUT and performs a registered synchronous read of a local DEPTH x DATA_W array.
- Returns the data on a ready/valid channel with full backpressure, replacing the bench's zero-latency combinational model.
- A host-side init write port preloads operand contents before `in3` start is released.

---
 rtl/ld_mem_pkg.sv | 16 +
 rtl/hs_fifo2.sv | 58 +++++
 rtl/ld_mem_port.sv | 105 ++++++++++
 tb/tb_ld_mem_port.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ld_mem_pkg.sv
// Shared types and defaults for the load-port memory server.
// Imported by ld_mem_port and hs_fifo2.
package ld_mem_pkg;

    localparam int LD_ADDR_W  = 4;
    localparam int LD_DATA_W  = 32;
    localparam int LD_DEPTH   = 16;
    localparam int FIFO_DEPTH = 2;

    // One read-response beat at the default data width.
    typedef struct packed {
        logic [LD_DATA_W-1:0] data;
        logic                 oob;
    } ld_beat_t;

endpackage

// File: rtl/hs_fifo2.sv
// Two-entry first-word-fall-through handshake FIFO, async active-low reset.
// Ports: push/push_data in, pop in, head/count/full/empty out.
module hs_fifo2
    import ld_mem_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] ent [FIFO_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'(FIFO_DEPTH));
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = ent[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ent[0] <= '0;
            ent[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                ent[wr_ptr] <= push_data;
                wr_ptr      <= !wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= !rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (
        @(posedge clock) disable iff (!reset) !(push && full)
    );

endmodule

// File: rtl/ld_mem_port.sv
// Memory-side server for one handshake load port: synchronous array read
// into a 2-entry FWFT output FIFO, plus a host init write port.
// Ports: ld_addr/valid/ready in, ld_data/valid/ready out, init_* host
// writes, oob_err sticky out-of-range flag, busy while data is pending.
module ld_mem_port
    import ld_mem_pkg::*;
#(
    parameter int    ADDR_W    = LD_ADDR_W,
    parameter int    DATA_W    = LD_DATA_W,
    parameter int    DEPTH     = LD_DEPTH,
    parameter string INIT_FILE = ""
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              ld_addr_valid,
    output logic              ld_addr_ready,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_data_valid,
    input  logic              ld_data_ready,
    input  logic              init_we,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data,
    output logic              oob_err,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              oob;
    } beat_t;

    if (DEPTH > (1 << ADDR_W) || IDX_W > ADDR_W) begin : g_bad_depth
        $error("ld_mem_port: DEPTH exceeds the address space");
    end

    if (INIT_FILE != "") begin : g_init_file
        $warning("ld_mem_port: INIT_FILE ignored, preload via init_we");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    beat_t             rd_beat;
    logic              ld_in_range;
    logic              init_in_range;
    logic              accept;
    logic              pop;
    logic              oob_q;
    logic [1:0]        fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign ld_in_range   = 32'(ld_addr) < 32'(DEPTH);
    assign init_in_range = 32'(init_addr) < 32'(DEPTH);

    // Credit comes from registered FIFO state only; an init write
    // steals the cycle so the read never races the array update.
    assign ld_addr_ready = reset && !init_we && !fifo_full;
    assign accept        = ld_addr_valid && ld_addr_ready;
    assign pop           = ld_data_valid && ld_data_ready;
    assign ld_data_valid = !fifo_empty;
    assign busy          = fifo_count != 2'd0;
    assign oob_err       = oob_q;

    always_comb begin
        rd_beat = '0;
        if (ld_in_range) begin
            rd_beat.data = mem[ld_addr[IDX_W-1:0]];
        end else begin
            rd_beat.oob = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (init_we && init_in_range) begin
            mem[init_addr[IDX_W-1:0]] <= init_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            oob_q <= 1'b0;
        end else if (accept && rd_beat.oob) begin
            oob_q <= 1'b1;
        end
    end

    // The FIFO entry register is the read register: the array word is
    // captured at the accept edge, giving one cycle of latency.
    hs_fifo2 #(
        .W(DATA_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (accept),
        .push_data (rd_beat.data),
        .pop       (pop),
        .head      (ld_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_ld_mem_port.sv
// Scoreboard bench for ld_mem_port (DEPTH=12 to exercise out-of-range).
// Stimulus pushes expected words on accept; a monitor pops on each beat.
module tb_ld_mem_port;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic        ld_addr_valid = 1'b0;
    logic        ld_addr_ready;
    logic [31:0] ld_data;
    logic        ld_data_valid;
    logic        ld_data_ready = 1'b1;
    logic        init_we = 1'b0;
    logic [3:0]  init_addr = '0;
    logic [31:0] init_data = '0;
    logic        oob_err;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int acc_cnt = 0;
    int last_acc = 0;
    int last_tries = 0;
    int pops_at_acc = 0;
    logic [31:0] exp_q [$];

    ld_mem_port #(
        .ADDR_W(4),
        .DATA_W(32),
        .DEPTH(12),
        .INIT_FILE("")
    ) u_dut (
        .clock         (clock),
        .reset         (reset),
        .ld_addr       (ld_addr),
        .ld_addr_valid (ld_addr_valid),
        .ld_addr_ready (ld_addr_ready),
        .ld_data       (ld_data),
        .ld_data_valid (ld_data_valid),
        .ld_data_ready (ld_data_ready),
        .init_we       (init_we),
        .init_addr     (init_addr),
        .init_data     (init_data),
        .oob_err       (oob_err),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every beat taken by the consumer is checked in order.
    always @(negedge clock) begin
        if (reset && ld_data_valid && ld_data_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got %h want none", ld_data);
            end else begin
                chk("beat_data", ld_data, exp_q.pop_front());
            end
        end
    end

    task automatic init_wr(input logic [3:0] a, input logic [31:0] d);
        init_we   = 1'b1;
        init_addr = a;
        init_data = d;
        @(posedge clock);
        #1;
        init_we = 1'b0;
    endtask

    task automatic send(input logic [3:0] a, input logic [31:0] e);
        bit got;
        got = 1'b0;
        last_tries = 0;
        ld_addr = a;
        ld_addr_valid = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clock);
            last_tries++;
            if (ld_addr_ready) begin
                got = 1'b1;
                exp_q.push_back(e);
                last_acc = cyc;
                acc_cnt++;
                pops_at_acc = pop_cnt;
            end
            @(posedge clock);
            #1;
        end
        ld_addr_valid = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no accept want addr %0d", a);
        end
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 60 && !idle; n++) begin
            @(negedge clock);
            if (!busy && exp_q.size() == 0) idle = 1'b1;
        end
        checks++;
        if (!idle) begin
            failures++;
            $display("FAIL drain_timeout: got busy want idle");
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int first;
        int acc0;
        int pb;
        bit rdy_seen;
        bit unstable;

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_data_valid", 32'(ld_data_valid), 0);
        chk("rst_addr_ready", 32'(ld_addr_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_oob", 32'(oob_err), 0);
        chk("rst_data", ld_data, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Single load, 1-cycle latency.
        init_wr(4'd3, 32'h2A);
        send(4'd3, 32'h2A);
        @(negedge clock);
        chk("lat_valid", 32'(ld_data_valid), 1);
        chk("lat_data", ld_data, 32'h2A);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("lat_busy_clear", 32'(busy), 0);
        chk("lat_oob", 32'(oob_err), 0);
        @(posedge clock);
        #1;

        // Streaming 0..15; 12..15 are out of range.
        for (int i = 0; i < 12; i++) init_wr(4'(i), 32'(i * 3));
        init_wr(4'd13, 32'hBEEF);
        @(negedge clock);
        chk("init_oob_no_flag", 32'(oob_err), 0);
        @(posedge clock);
        #1;
        acc0 = acc_cnt;
        first = 0;
        for (int i = 0; i < 16; i++) begin
            send(4'(i), (i < 12) ? 32'(i * 3) : 32'h0);
            if (i == 0) first = last_acc;
        end
        chk("stream_accepts", 32'(acc_cnt - acc0), 16);
        chk("stream_no_bubble", 32'(last_acc - first), 15);
        wait_idle();
        chk("stream_oob", 32'(oob_err), 1);

        // Backpressure.
        ld_data_ready = 1'b0;
        acc0 = acc_cnt;
        send(4'd5, 32'd15);
        send(4'd6, 32'd18);
        ld_addr = 4'd7;
        ld_addr_valid = 1'b1;
        rdy_seen = 1'b0;
        unstable = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            if (ld_addr_ready) rdy_seen = 1'b1;
            if (!ld_data_valid || ld_data !== 32'd15) unstable = 1'b1;
            @(posedge clock);
            #1;
        end
        chk("bp_two_accepted", 32'(acc_cnt - acc0), 2);
        chk("bp_ready_low", 32'(rdy_seen), 0);
        chk("bp_head_hold", 32'(unstable), 0);
        ld_data_ready = 1'b1;
        pb = pop_cnt;
        send(4'd7, 32'd21);
        chk("bp_third_after_pop", 32'(pops_at_acc > pb), 1);
        wait_idle();

        // Out of range word returns 0; flag stays set.
        send(4'd14, 32'h0);
        send(4'd4, 32'd12);
        wait_idle();
        chk("oob_sticky", 32'(oob_err), 1);

        // Init write collides with a load request.
        init_we = 1'b1;
        init_addr = 4'd2;
        init_data = 32'hDEAD;
        ld_addr = 4'd2;
        ld_addr_valid = 1'b1;
        @(negedge clock);
        chk("collide_ready_low", 32'(ld_addr_ready), 0);
        @(posedge clock);
        #1;
        init_we = 1'b0;
        send(4'd2, 32'hDEAD);
        chk("collide_next_accept", 32'(last_tries), 1);
        wait_idle();

        // Reset with the FIFO full.
        ld_data_ready = 1'b0;
        send(4'd0, 32'd0);
        send(4'd1, 32'd3);
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ld_data_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ready", 32'(ld_addr_ready), 0);
        chk("mid_rst_oob", 32'(oob_err), 0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        ld_data_ready = 1'b1;
        send(4'd3, 32'd9);
        send(4'd2, 32'hDEAD);
        wait_idle();
        chk("post_rst_oob", 32'(oob_err), 0);
        send(4'd12, 32'h0);
        wait_idle();
        chk("post_rst_oob_set", 32'(oob_err), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
